// File: rtl/data_memory_pkg.sv
// data_memory_pkg: register map, CTRL bit positions and decode result type
package data_memory_pkg;
  localparam logic [31:0] GPIO_OUT_OFS = 32'h00;
  localparam logic [31:0] GPIO_IN_OFS  = 32'h04;
  localparam logic [31:0] CTRL_OFS     = 32'h08;
  localparam logic [31:0] CNT_OFS      = 32'h0C;
  localparam logic [31:0] CMP_OFS      = 32'h10;
  localparam logic [31:0] STAT_OFS     = 32'h14;
  localparam logic [31:0] ERR_CLR_OFS  = 32'h18;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_AR  = 1;
  localparam int CTRL_IRQ = 2;
  typedef enum logic [3:0] {
    SEL_RAM, SEL_GPIO_OUT, SEL_GPIO_IN, SEL_CTRL, SEL_CNT, SEL_CMP, SEL_STAT, SEL_ERR, SEL_NONE
  } sel_e;
endpackage

// File: rtl/data_memory_system_mmio_timer.sv
// mmio_timer: 32-bit compare timer with auto-reload, sticky match flag and level irq
module mmio_timer
  import data_memory_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] write_data,
  input  logic        wr_ctrl,
  input  logic        wr_cnt,
  input  logic        wr_cmp,
  input  logic        wr_stat,
  output logic [2:0]  ctrl,
  output logic [31:0] cnt,
  output logic [31:0] cmp,
  output logic        match_flag,
  output logic        timer_irq
);
  logic hit;
  assign hit = ctrl[CTRL_EN] && cnt == cmp;
  assign timer_irq = match_flag && ctrl[CTRL_IRQ];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ctrl       <= '0;
      cnt        <= '0;
      cmp        <= '1;
      match_flag <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= write_data[2:0];
      if (wr_cmp) cmp <= write_data;
      // a CPU write to CNT suppresses both the increment and the compare
      if (wr_cnt) cnt <= write_data;
      else if (ctrl[CTRL_EN]) cnt <= (hit && ctrl[CTRL_AR]) ? '0 : cnt + 32'd1;
      if (hit && !wr_cnt) match_flag <= 1'b1;
      else if (wr_stat && write_data[0]) match_flag <= 1'b0;
    end
endmodule

// File: rtl/data_memory_system.sv
// data_memory_system: word RAM plus GPIO and compare-timer registers behind the processor data port
module data_memory_system
  import data_memory_pkg::*;
#(
  parameter int          RAM_WORDS = 64,
  parameter int          GPIO_W    = 8,
  parameter logic [31:0] IO_BASE   = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       direction,
  input  logic [31:0]       write_data,
  input  logic              mem_write,
  output logic [31:0]       read_data,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              timer_irq,
  output logic              bad_addr
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] addr, ofs, cnt, cmp;
  logic [2:0] ctrl;
  logic match_flag, ram_we;
  logic [GPIO_W-1:0] gpio_s1, gpio_s2;
  sel_e sel;
  assign addr = direction & ~32'h3;
  assign ofs = addr - IO_BASE;
  always_comb
    sel = addr < 32'(RAM_WORDS * 4) ? SEL_RAM
        : addr < IO_BASE             ? SEL_NONE
        : ofs == GPIO_OUT_OFS        ? SEL_GPIO_OUT
        : ofs == GPIO_IN_OFS         ? SEL_GPIO_IN
        : ofs == CTRL_OFS            ? SEL_CTRL
        : ofs == CNT_OFS             ? SEL_CNT
        : ofs == CMP_OFS             ? SEL_CMP
        : ofs == STAT_OFS            ? SEL_STAT
        : ofs == ERR_CLR_OFS         ? SEL_ERR
        :                              SEL_NONE;
  always_comb
    read_data = sel == SEL_RAM      ? ram[direction[AW+1:2]]
              : sel == SEL_GPIO_OUT ? 32'(gpio_out)
              : sel == SEL_GPIO_IN  ? 32'(gpio_s2)
              : sel == SEL_CTRL     ? 32'(ctrl)
              : sel == SEL_CNT      ? cnt
              : sel == SEL_CMP      ? cmp
              : sel == SEL_STAT     ? 32'(match_flag)
              :                       '0;
  // reset held low blocks a store that coincides with the edge
  assign ram_we = reset && mem_write && sel == SEL_RAM;
  always_ff @(posedge clk)
    if (ram_we) ram[direction[AW+1:2]] <= write_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      gpio_out <= '0;
      gpio_s1  <= '0;
      gpio_s2  <= '0;
      bad_addr <= 1'b0;
    end else begin
      gpio_s1 <= gpio_in;
      gpio_s2 <= gpio_s1;
      if (mem_write && sel == SEL_GPIO_OUT) gpio_out <= write_data[GPIO_W-1:0];
      if (mem_write && sel == SEL_NONE) bad_addr <= 1'b1;
      else if (mem_write && sel == SEL_ERR) bad_addr <= 1'b0;
    end
  mmio_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .write_data (write_data),
    .wr_ctrl    (mem_write && sel == SEL_CTRL),
    .wr_cnt     (mem_write && sel == SEL_CNT),
    .wr_cmp     (mem_write && sel == SEL_CMP),
    .wr_stat    (mem_write && sel == SEL_STAT),
    .ctrl       (ctrl),
    .cnt        (cnt),
    .cmp        (cmp),
    .match_flag (match_flag),
    .timer_irq  (timer_irq)
  );
endmodule

// File: tb/tb_data_memory_system.sv
// tb_data_memory_system: random and directed stimulus checked against a behavioural memory-map model
module tb_data_memory_system;
  localparam int RW = 64;
  localparam logic [31:0] IOB = 32'h0000_1000;
  logic clk = 0, reset = 0, mem_write = 0;
  logic [31:0] direction = 0, write_data = 0, read_data;
  logic [7:0] gpio_out, gpio_in = 0, gin = 0;
  logic timer_irq, bad_addr;
  int checks = 0, errors = 0;
  data_memory_system #(.RAM_WORDS(RW), .GPIO_W(8), .IO_BASE(IOB)) dut (
    .clk(clk), .reset(reset), .direction(direction), .write_data(write_data),
    .mem_write(mem_write), .read_data(read_data), .gpio_out(gpio_out),
    .gpio_in(gpio_in), .timer_irq(timer_irq), .bad_addr(bad_addr));
  always #5 clk = ~clk;
  logic [31:0] m_ram [RW];
  bit m_val [RW];
  logic [7:0] m_gout;
  logic [7:0] m_gin [2];
  logic [2:0] m_ctrl;
  logic [31:0] m_cnt, m_cmp;
  bit m_flag, m_bad;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void m_reset();
    m_gout = 0; m_gin[0] = 0; m_gin[1] = 0;
    m_ctrl = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_flag = 0; m_bad = 0;
  endfunction
  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    logic [31:0] w = {a[31:2], 2'b00};
    known = 1;
    if (w < RW * 4) begin
      known = m_val[w[7:2]];
      return m_ram[w[7:2]];
    end
    if (w < IOB) return 0;
    case (w - IOB)
      32'h00: return {24'b0, m_gout};
      32'h04: return {24'b0, m_gin[1]};
      32'h08: return {29'b0, m_ctrl};
      32'h0C: return m_cnt;
      32'h10: return m_cmp;
      32'h14: return {31'b0, m_flag};
      default: return 0;
    endcase
  endfunction
  // one clock edge of the memory map, evaluated from the inputs present at that edge
  function automatic void m_edge();
    logic [31:0] w, o;
    bit io, hit, wcnt;
    if (!reset) begin
      m_reset();
      return;
    end
    w = {direction[31:2], 2'b00};
    o = w - IOB;
    io = w >= IOB && o <= 32'h18;
    hit = m_ctrl[0] && m_cnt == m_cmp;
    wcnt = mem_write && io && o == 32'h0C;
    m_gin[1] = m_gin[0];
    m_gin[0] = gpio_in;
    if (wcnt) m_cnt = write_data;
    else if (m_ctrl[0]) m_cnt = (hit && m_ctrl[1]) ? 0 : m_cnt + 1;
    if (hit && !wcnt) m_flag = 1;
    else if (mem_write && io && o == 32'h14 && write_data[0]) m_flag = 0;
    if (mem_write) begin
      if (w < RW * 4) begin
        m_ram[w[7:2]] = write_data;
        m_val[w[7:2]] = 1;
      end else if (!io) m_bad = 1;
      else case (o)
        32'h00: m_gout = write_data[7:0];
        32'h08: m_ctrl = write_data[2:0];
        32'h10: m_cmp = write_data;
        32'h18: m_bad = 0;
        default: ;
      endcase
    end
  endfunction
  task automatic compare();
    bit k;
    logic [31:0] e;
    e = m_read(direction, k);
    if (k) check("read_data", read_data, e);
    check("gpio_out", 32'(gpio_out), 32'(m_gout));
    check("timer_irq", 32'(timer_irq), 32'(m_flag && m_ctrl[2]));
    check("bad_addr", 32'(bad_addr), 32'(m_bad));
  endtask
  task automatic step(input logic [31:0] a, input logic [31:0] d, input bit we,
                      input bit lit = 0, input logic [31:0] exp = 0, input string nm = "");
    @(negedge clk);
    direction = a; write_data = d; mem_write = we; gpio_in = gin;
    #1 compare();
    if (lit) check(nm, read_data, exp);
    @(posedge clk) m_edge();
  endtask
  initial begin
    logic [31:0] a, d;
    m_reset();
    @(negedge clk);
    direction = IOB + 32'h10;
    #1 compare();
    check("rst_cmp", read_data, 32'hFFFF_FFFF);
    check("rst_irq", 32'(timer_irq), 0);
    @(posedge clk) m_edge();
    @(negedge clk) reset = 1;
    @(posedge clk) m_edge();
    step(32'h10, 32'hDEAD_BEEF, 1);
    step(32'h10, 0, 0, 1, 32'hDEAD_BEEF, "ram_rd");
    step(32'h13, 0, 0, 1, 32'hDEAD_BEEF, "ram_rd_unaligned");
    step(IOB, 32'h1234_56A5, 1);
    #2 check("gpio_out_lit", 32'(gpio_out), 32'hA5);
    step(IOB, 0, 0, 1, 32'hA5, "gpio_rd");
    gin = 8'h3C;
    step(IOB + 4, 0, 0, 1, 0, "gin_0edge");
    step(IOB + 4, 0, 0, 1, 0, "gin_1edge");
    step(IOB + 4, 32'hFF, 1, 1, 32'h3C, "gin_2edge");
    step(IOB + 32'h10, 3, 1);
    step(IOB + 32'h0C, 0, 1);
    step(IOB + 32'h08, 7, 1);
    step(IOB + 32'h0C, 0, 0, 1, 0, "cnt0");
    step(IOB + 32'h0C, 0, 0, 1, 1, "cnt1");
    step(IOB + 32'h0C, 0, 0, 1, 2, "cnt2");
    step(IOB + 32'h0C, 0, 0, 1, 3, "cnt3");
    #2 check("irq_set", 32'(timer_irq), 1);
    step(IOB + 32'h0C, 0, 0, 1, 0, "cnt_reload");
    step(IOB + 32'h10, 5, 1);
    step(IOB + 32'h14, 1, 1);
    #2 check("irq_clr", 32'(timer_irq), 0);
    step(IOB + 32'h14, 0, 0, 1, 0, "flag_clr");
    step(IOB + 32'h0C, 32'hFFFF_FFFF, 1);
    step(IOB + 32'h0C, 0, 0, 1, 32'hFFFF_FFFF, "cnt_wr_wins");
    step(IOB + 32'h0C, 0, 0, 1, 0, "cnt_wrap");
    step(IOB + 32'h14, 0, 0, 1, 0, "wrap_no_flag");
    step(IOB + 32'h0C, 5, 1);
    step(IOB + 32'h14, 1, 1);
    step(IOB + 32'h14, 0, 0, 1, 1, "set_wins");
    step(IOB, 32'hFF, 1);
    @(negedge clk);
    direction = IOB; write_data = 32'h55; mem_write = 1;
    #2 reset = 0;
    m_reset();
    #1 check("arst_gpio", 32'(gpio_out), 0);
    check("arst_irq", 32'(timer_irq), 0);
    direction = IOB + 32'h0C;
    #1 check("arst_cnt", read_data, 0);
    direction = IOB;
    @(posedge clk) m_edge();
    @(negedge clk) begin reset = 1; mem_write = 0; end
    @(posedge clk) m_edge();
    step(IOB, 0, 0, 1, 0, "gpio_after_rst");
    step(32'h10, 0, 0, 1, 32'hDEAD_BEEF, "ram_kept");
    step(32'h2000, 32'h1, 1, 1, 0, "bad_wr_rd");
    #2 check("bad_set", 32'(bad_addr), 1);
    step(32'h2000, 0, 0, 1, 0, "bad_rd");
    #2 check("bad_hold", 32'(bad_addr), 1);
    step(IOB + 32'h18, 0, 1, 1, 0, "err_rd");
    #2 check("bad_clr", 32'(bad_addr), 0);
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 4))
        0, 1: a = $urandom_range(0, RW * 4 - 1);
        2, 3: a = IOB + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3));
        default: a = $urandom_range(0, 1) ? (IOB + 32'h1C + 32'(4 * $urandom_range(0, 8)))
                                          : ($urandom | 32'h8000_0000);
      endcase
      d = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) gin = 8'($urandom);
      step(a, d, $urandom_range(0, 2) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_memory_system.md
Name: data_memory_system

Overview:
Data-side memory subsystem that sits directly downstream of the single-cycle processor. It consumes the processor's direction, write_data and mem_write outputs and returns read_data combinationally in the same cycle. It decodes each address into a word RAM or one of a small set of memory-mapped peripherals: GPIO plus a 32-bit compare timer with a sticky match flag and an interrupt line.

Parameters:
RAM_WORDS, 64, number of 32-bit RAM words; must be a power of 2 and at most 1024.
GPIO_W, 8, width of the GPIO output and input ports.
IO_BASE, 32'h0000_1000, base address of the peripheral register block.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset; the block is in reset while reset is 0.
direction  in  32  byte address from the processor; bits [1:0] are ignored (word access only).
write_data  in  32  store data from the processor.
mem_write  in  1  store strobe; sampled on the rising clk edge.
read_data  out  32  load data, combinational from direction and current state.
gpio_out  out  GPIO_W  GPIO output register.
gpio_in  in  GPIO_W  asynchronous external inputs.
timer_irq  out  1  asserted when match_flag=1 and irq_en=1.
bad_addr  out  1  sticky error flag: an access hit an unmapped address.

Behaviour:
- Address map (word offset = direction[31:2]):
  - RAM: direction < RAM_WORDS*4. Index is direction[log2(RAM_WORDS)+1:2].
  - IO_BASE+0x00 GPIO_OUT: RW, bits [GPIO_W-1:0]; upper bits read 0.
  - IO_BASE+0x04 GPIO_IN: RO. Holds gpio_in passed through a 2-flop synchroniser. Writes are ignored.
  - IO_BASE+0x08 TIMER_CTRL: RW. bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - IO_BASE+0x0C TIMER_CNT: RW, 32 bits.
  - IO_BASE+0x10 TIMER_CMP: RW, 32 bits.
  - IO_BASE+0x14 TIMER_STAT: bit0 match_flag. Writing 1 to bit0 clears it; writing 0 has no effect.
  - IO_BASE+0x18 ERR_CLR: a write of any value clears bad_addr; reads return 0.
  - Any other address: read_data=0, writes are dropped.
- Unmapped access:
  - Any write to an unmapped address sets bad_addr.
  - A read from an unmapped address does not set bad_addr, because a read cannot be told apart from an idle address.
- Reads: purely combinational, zero-cycle latency. read_data reflects register values from before the current edge.
- Writes: take effect on the rising edge when mem_write=1. A read of the same address in the following cycle returns the new value.
- Reset (reset=0, asynchronous):
  - gpio_out=0, CTRL=0, CNT=0, CMP=32'hFFFF_FFFF.
  - match_flag=0, bad_addr=0, synchroniser flops=0.
  - timer_irq=0, and read_data follows the decode of the reset state.
  - RAM contents are NOT reset and are undefined until first written.
  - Reset asserted mid-operation overrides any pending write in that cycle.
- Timer, per rising edge, in priority order:
  1. CPU write to TIMER_CNT: CNT <= write_data. No increment or compare action that cycle.
  2. Otherwise, if enable=1 and CNT==CMP: set match_flag. Then CNT <= 0 if auto_reload=1, else CNT <= CNT+1.
  3. Otherwise, if enable=1: CNT <= CNT+1, wrapping from 32'hFFFF_FFFF to 0 with no flag.
  4. With enable=0, CNT holds and the compare is not evaluated.
- match_flag: a set event and a write-1-clear in the same cycle resolve to set (set wins).
- CMP or CTRL writes take effect for the compare on the next edge.
- timer_irq is a combinational AND of match_flag and irq_en; it is level-sensitive, not a pulse.
- The GPIO_IN synchroniser samples every cycle, so a gpio_in change appears in reads 2 clk edges later.

Decomposition:
- Package data_memory_pkg holds:
  - register offset localparams: GPIO_OUT_OFS, GPIO_IN_OFS, CTRL_OFS, CNT_OFS, CMP_OFS, STAT_OFS, ERR_CLR_OFS;
  - CTRL bit-index constants;
  - a typedef enum for the address-decode result: SEL_RAM, SEL_GPIO_OUT, SEL_GPIO_IN, SEL_CTRL, SEL_CNT, SEL_CMP, SEL_STAT, SEL_ERR, SEL_NONE.
- Sub-module mmio_timer: owns CTRL, CNT, CMP and match_flag, with a write strobe per register plus write_data. It outputs the register values and timer_irq.
- The top level holds the RAM array, GPIO, decode, the read mux and bad_addr.

Test Plan:
- RAM store/load: reset released; write 32'hDEADBEEF to 0x0000_0010; next cycle read 0x0000_0010 -> read_data=32'hDEADBEEF. Read 0x0000_0013 -> same value, since bits [1:0] are ignored.
- GPIO: write 32'h1234_56A5 to IO_BASE+0x00 -> gpio_out=8'hA5, read back 32'h0000_00A5. Drive gpio_in=8'h3C -> IO_BASE+0x04 reads 8'h3C after 2 edges, and 0 before.
- Timer auto-reload: CMP=3, CTRL=3'b111, CNT=0 -> CNT counts 1,2,3. On the edge where CNT==3: match_flag=1, timer_irq=1, CNT=0 next. Write 1 to STAT -> timer_irq=0.
- Priority: with enable=1, write CNT=32'hFFFF_FFFF -> CNT=32'hFFFF_FFFF that cycle, then 0 next with no flag (CMP=5). A set and a clear on the same edge -> match_flag stays 1.
- Bad address: write to 0x0000_2000 -> bad_addr=1 and read_data=0. A read of 0x0000_2000 leaves bad_addr unchanged. Write to IO_BASE+0x18 -> bad_addr=0.
- Async reset mid-run: timer running with gpio_out=8'hFF; drop reset between clock edges -> gpio_out=0, CNT=0, timer_irq=0 immediately without a clk edge. RAM word written earlier is unaffected on read after release.
